// File: rtl/rs_encode_stream_in_seg.sv
// RS encoder front end: cuts the input line stream into NUM_LINES-line RS blocks.
// Each block holds up to DATA_LINES data lines followed by zero pad lines.
module rs_encode_stream_in_seg #(
  parameter int unsigned DATA_W           = 256,
  parameter int unsigned DATA_LINES       = 7,
  parameter int unsigned NUM_LINES        = 8,
  parameter int unsigned NUM_REQ_BLOCKS_W = 16,
  parameter int unsigned NUM_LINES_W      = $clog2(NUM_LINES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        src_stream_encoder_req_val,
  input  logic [NUM_REQ_BLOCKS_W-1:0] src_stream_encoder_req_num_blocks,
  input  logic [NUM_LINES_W-1:0]      src_stream_encoder_req_last_lines,
  output logic                        stream_encoder_src_req_rdy,
  input  logic                        src_stream_encoder_data_val,
  input  logic [DATA_W-1:0]           src_stream_encoder_data,
  output logic                        stream_encoder_src_data_rdy,
  output logic                        stream_encode_line_val,
  output logic [DATA_W-1:0]           stream_encode_line_encode_line,
  output logic                        stream_encode_line_first,
  output logic                        stream_encode_line_last,
  input  logic                        stream_encode_line_rdy,
  output logic                        in_datap_out_datap_meta_val,
  output logic [NUM_REQ_BLOCKS_W-1:0] in_datap_out_datap_req_num_blocks,
  input  logic                        out_datap_in_datap_meta_rdy
);

  localparam int unsigned BLK_CNT_W = NUM_REQ_BLOCKS_W + 1;

  typedef enum logic [1:0] {ST_READY, ST_META, ST_DATA, ST_PAD} state_t;

  state_t                      state_q, state_d;
  logic [NUM_REQ_BLOCKS_W-1:0] num_blocks_q, num_blocks_d;
  logic [NUM_LINES_W-1:0]      last_lines_q, last_lines_d;
  logic [NUM_LINES_W-1:0]      line_cnt_q, line_cnt_d;
  logic [BLK_CNT_W-1:0]        block_cnt_q, block_cnt_d;
  logic [NUM_LINES_W-1:0]      lim;
  logic                        last_block, cnt_top, lim_end, block_end;

  // Extra block_cnt bit keeps the final-block compare exact at the maximum count.
  assign last_block = (block_cnt_q + BLK_CNT_W'(1)) == BLK_CNT_W'(num_blocks_q);
  assign lim        = last_block ? last_lines_q : NUM_LINES_W'(DATA_LINES);
  assign cnt_top    = line_cnt_q == NUM_LINES_W'(NUM_LINES - 1);
  assign lim_end    = line_cnt_q == (lim - NUM_LINES_W'(1));

  assign in_datap_out_datap_req_num_blocks = num_blocks_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_READY;
      num_blocks_q <= '0;
      last_lines_q <= '0;
      line_cnt_q   <= '0;
      block_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      num_blocks_q <= num_blocks_d;
      last_lines_q <= last_lines_d;
      line_cnt_q   <= line_cnt_d;
      block_cnt_q  <= block_cnt_d;
    end
  end

  // Next state, counters and handshake outputs; the data path is a pure pass-through.
  always_comb begin
    state_d      = state_q;
    num_blocks_d = num_blocks_q;
    last_lines_d = last_lines_q;
    line_cnt_d   = line_cnt_q;
    block_cnt_d  = block_cnt_q;
    block_end    = 1'b0;

    stream_encoder_src_req_rdy     = 1'b0;
    stream_encoder_src_data_rdy    = 1'b0;
    stream_encode_line_val         = 1'b0;
    stream_encode_line_encode_line = '0;
    stream_encode_line_first       = 1'b0;
    stream_encode_line_last        = 1'b0;
    in_datap_out_datap_meta_val    = 1'b0;

    case (state_q)
      ST_READY: begin
        stream_encoder_src_req_rdy = 1'b1;
        if (src_stream_encoder_req_val) begin
          num_blocks_d = src_stream_encoder_req_num_blocks;
          if ((src_stream_encoder_req_last_lines == '0) ||
              (src_stream_encoder_req_last_lines > NUM_LINES_W'(DATA_LINES)))
            last_lines_d = NUM_LINES_W'(DATA_LINES);
          else
            last_lines_d = src_stream_encoder_req_last_lines;
          if (src_stream_encoder_req_num_blocks != '0) state_d = ST_META;
        end
      end
      ST_META: begin
        in_datap_out_datap_meta_val = 1'b1;
        if (out_datap_in_datap_meta_rdy) begin
          block_cnt_d = '0;
          line_cnt_d  = '0;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        stream_encode_line_val         = src_stream_encoder_data_val;
        stream_encoder_src_data_rdy    = stream_encode_line_rdy;
        stream_encode_line_encode_line = src_stream_encoder_data;
        stream_encode_line_first       = line_cnt_q == '0;
        stream_encode_line_last        = cnt_top;
        if (src_stream_encoder_data_val && stream_encode_line_rdy) begin
          if (cnt_top) begin
            block_end = 1'b1;
          end else begin
            line_cnt_d = line_cnt_q + NUM_LINES_W'(1);
            if (lim_end) state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        stream_encode_line_val  = 1'b1;
        stream_encode_line_last = cnt_top;
        if (stream_encode_line_rdy) begin
          if (cnt_top) block_end = 1'b1;
          else         line_cnt_d = line_cnt_q + NUM_LINES_W'(1);
        end
      end
      default: state_d = ST_READY;
    endcase

    if (block_end) begin
      line_cnt_d = '0;
      if (last_block) begin
        state_d = ST_READY;
      end else begin
        block_cnt_d = block_cnt_q + BLK_CNT_W'(1);
        state_d     = ST_DATA;
      end
    end
  end

endmodule

// File: tb/tb_rs_encode_stream_in_seg.sv
// Randomized bench for rs_encode_stream_in_seg against a queue-based block model.
module tb_rs_encode_stream_in_seg;
  localparam int unsigned DATA_W     = 256;
  localparam int unsigned NRB_W      = 16;
  localparam int unsigned NL_W       = 4;
  localparam int          DATA_LINES = 7;
  localparam int          NUM_LINES  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_val = 1'b0;
  logic [NRB_W-1:0]  req_nb = '0;
  logic [NL_W-1:0]   req_ll = '0;
  logic              req_rdy;
  logic              data_val = 1'b0;
  logic [DATA_W-1:0] src_data = '0;
  logic              data_rdy;
  logic              line_val;
  logic [DATA_W-1:0] line_data;
  logic              line_first, line_last;
  logic              line_rdy = 1'b0;
  logic              meta_val;
  logic [NRB_W-1:0]  meta_nb;
  logic              meta_rdy = 1'b0;

  rs_encode_stream_in_seg dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .src_stream_encoder_req_val        (req_val),
    .src_stream_encoder_req_num_blocks (req_nb),
    .src_stream_encoder_req_last_lines (req_ll),
    .stream_encoder_src_req_rdy        (req_rdy),
    .src_stream_encoder_data_val       (data_val),
    .src_stream_encoder_data           (src_data),
    .stream_encoder_src_data_rdy       (data_rdy),
    .stream_encode_line_val            (line_val),
    .stream_encode_line_encode_line    (line_data),
    .stream_encode_line_first          (line_first),
    .stream_encode_line_last           (line_last),
    .stream_encode_line_rdy            (line_rdy),
    .in_datap_out_datap_meta_val       (meta_val),
    .in_datap_out_datap_req_num_blocks (meta_nb),
    .out_datap_in_datap_meta_rdy       (meta_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    bit                first;
    bit                last;
    bit                pad;
  } line_t;

  line_t             exp_q[$];
  logic [DATA_W-1:0] src_q[$];
  int                n_chk = 0;
  int                n_pass = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic int eff_lines(input int ll);
    return (ll == 0 || ll > DATA_LINES) ? DATA_LINES : ll;
  endfunction

  // Expected output: each block is n data lines then NUM_LINES-n zero lines.
  task automatic build(input int nb, input int ll);
    line_t l;
    int    n;
    for (int b = 0; b < nb; b++) begin
      n = (b == nb - 1) ? eff_lines(ll) : DATA_LINES;
      for (int i = 0; i < NUM_LINES; i++) begin
        l.first = (i == 0);
        l.last  = (i == NUM_LINES - 1);
        l.pad   = (i >= n);
        if (l.pad) l.d = '0;
        else begin
          l.d = rand_word();
          src_q.push_back(l.d);
        end
        exp_q.push_back(l);
      end
    end
  endtask

  task automatic run_req(input int nb, input int ll, input int p_rdy, input int p_val,
                         input int meta_wait, input int abort_at);
    int    data_xfers;
    int    exp_data;
    int    exp_lines;
    int    lines;
    int    cyc;
    line_t front;
    data_xfers = 0;
    lines      = 0;
    cyc        = 0;
    build(nb, ll);
    exp_data  = src_q.size();
    exp_lines = exp_q.size();

    @(negedge clk);
    req_val = 1'b1;
    req_nb  = NRB_W'(nb);
    req_ll  = NL_W'(ll);
    #1 chk("req_rdy", req_rdy, 1);
    @(negedge clk);
    req_val = 1'b0;
    #1;
    if (nb == 0) begin
      chk("zero_meta_val", meta_val, 0);
      chk("zero_line_val", line_val, 0);
      chk("zero_req_rdy", req_rdy, 1);
      return;
    end
    chk("meta_nb", meta_nb, nb);
    data_val = 1'b1;
    src_data = src_q[0];
    line_rdy = 1'b1;
    meta_rdy = 1'b0;
    for (int w = 0; w < meta_wait; w++) begin
      #1;
      chk("meta_wait_val", meta_val, 1);
      chk("meta_wait_data_rdy", data_rdy, 0);
      chk("meta_wait_line_val", line_val, 0);
      @(negedge clk);
    end
    meta_rdy = 1'b1;
    #1 chk("meta_val", meta_val, 1);
    @(negedge clk);
    meta_rdy = 1'b0;

    while (exp_q.size() > 0 && cyc < 3000) begin
      if (abort_at >= 0 && lines == abort_at) begin
        rst_n    = 1'b0;
        line_rdy = 1'b1;
        data_val = 1'b1;
        #1;
        chk("rst_line_val", line_val, 0);
        chk("rst_meta_val", meta_val, 0);
        chk("rst_data_rdy", data_rdy, 0);
        chk("rst_req_rdy", req_rdy, 1);
        exp_q.delete();
        src_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        data_val = 1'b0;
        line_rdy = 1'b0;
        return;
      end
      line_rdy = ($urandom_range(99) < p_rdy);
      data_val = (src_q.size() > 0) && ($urandom_range(99) < p_val);
      src_data = (src_q.size() > 0) ? src_q[0] : rand_word();
      #1;
      front = exp_q[0];
      chk("line_val", line_val, front.pad ? 1'b1 : data_val);
      chk("data_rdy", data_rdy, !front.pad && line_rdy);
      if (line_val && line_rdy) begin
        chk("line_data", line_data, front.d);
        chk("line_first", line_first, front.first);
        chk("line_last", line_last, front.last);
        void'(exp_q.pop_front());
        lines++;
      end
      if (data_val && data_rdy) begin
        void'(src_q.pop_front());
        data_xfers++;
      end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 3000) chk("timeout", 0, 1);
    chk("data_xfers", data_xfers, exp_data);
    chk("line_count", lines, exp_lines);
    line_rdy = 1'b1;
    data_val = 1'b1;
    #1;
    chk("end_req_rdy", req_rdy, 1);
    chk("end_line_val", line_val, 0);
    chk("end_data_rdy", data_rdy, 0);
    data_val = 1'b0;
    line_rdy = 1'b0;
  endtask

  initial begin
    data_val = 1'b1;
    line_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_rdy", req_rdy, 1);
    chk("reset_meta_val", meta_val, 0);
    chk("reset_line_val", line_val, 0);
    chk("reset_data_rdy", data_rdy, 0);
    chk("reset_meta_nb", meta_nb, 0);
    data_val = 1'b0;
    line_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_req(1, 0, 100, 100, 0, -1);
    run_req(3, 2, 100, 100, 0, -1);
    run_req(0, 3, 100, 100, 0, -1);
    run_req(4, 5, 60, 70, 0, -1);
    run_req(2, 1, 100, 100, 5, -1);
    run_req(3, 4, 80, 80, 0, 11);
    run_req(2, 9, 70, 70, 1, -1);
    run_req(1, 7, 50, 50, 0, -1);
    for (int i = 0; i < 5; i++)
      run_req($urandom_range(1, 5), $urandom_range(0, 15), $urandom_range(40, 100),
              $urandom_range(40, 100), $urandom_range(0, 3), -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
